// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, threshold flags,
// registered read port and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DATASIZE-1:0] wr_data,
  input  logic                rd_en,
  output logic [DATASIZE-1:0] rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;

  localparam logic [ADDRSIZE:0] DEPTH_W = PW'(DEPTH);
  localparam logic [ADDRSIZE:0] AF_W    = PW'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AE_W    = PW'(AEMPTY_THRESH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wr_ptr;
  logic [ADDRSIZE:0]   rd_ptr;
  logic [ADDRSIZE:0]   count_next;
  logic                wr_ok;
  logic                rd_ok;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // wrap bits make the pointer difference exact for 0..DEPTH
  assign count = wr_ptr - rd_ptr;

  assign count_next = count
                    + PW'(wr_ok)
                    - PW'(rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr[ADDRSIZE-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[ADDRSIZE-1:0]];
      end
      rd_valid     <= rd_ok;
      full         <= (count_next == DEPTH_W);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_W);
      almost_empty <= (count_next <= AE_W);
      // a new error event wins over a same-cycle clear
      overflow  <= (wr_en && full)
                || (overflow && !clr_err);
      underflow <= (rd_en && empty)
                || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and random stimulus against
// a queue-based reference model of the FIFO.
module tb_sync_fifo;

  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  sync_fifo #(
    .DATASIZE(8),
    .ADDRSIZE(4),
    .AFULL_THRESH(AFT),
    .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  logic [7:0] q[$];
  logic [7:0] m_rd;
  logic       m_rv;
  logic       m_ov;
  logic       m_un;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = 8'h00;
    m_rv = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_un));
  endtask

  // one clock cycle with the given requests, then model update and check
  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r, input logic c);
    logic was_full;
    logic was_empty;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    #1;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_rv = r && !was_empty;
    if (m_rv)
      m_rd = q.pop_front();
    if (w && !was_full)
      q.push_back(d);
    m_ov = (w && was_full) || (m_ov && !c);
    m_un = (r && was_empty) || (m_un && !c);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    check_all();
  endtask

  initial begin
    logic w;
    logic r;
    logic [7:0] d;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // fill completely
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10)
        chk("af_at_11", 32'(almost_full), 32'd0);
      if (i == 11)
        chk("af_at_12", 32'(almost_full), 32'd1);
    end
    chk("full16", 32'(full), 32'd1);
    chk("count16", 32'(count), 32'd16);

    // overflow attempt, then drain in order
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(rd_data), 32'(i));
      chk("drain_valid", 32'(rd_valid), 32'd1);
    end
    chk("empty_after", 32'(empty), 32'd1);

    // underflow, clear, and set-wins-over-clear
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_hold_data", 32'(rd_data), 32'h0F);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("unf_clr", 32'(underflow), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("unf_set_wins", 32'(underflow), 32'd1);

    // steady count of 5 with simultaneous traffic
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("steady_cnt", 32'(count), 32'd5);
      chk("steady_ae", 32'(almost_empty), 32'd0);
    end

    // random interleave with gaps, crosses the pointer wrap
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      d = 8'($urandom);
      cyc(w, d, r, 1'($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2))
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end

    // async reset in the middle of a cycle at count 9
    for (int i = 0; i < 40 && q.size() != 9; i++) begin
      if (q.size() < 9)
        cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      else
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pre_rst_cnt", 32'(count), 32'd9);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_data", 32'(rd_data), 32'h5C);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
